// File: rtl/dsa_sign_seq.sv
// dsa_sign_seq: DSA signature sequencer driving external modexp, modmul and modinv engines.
// Runs r = (g^k mod p) mod q and s = kinv*(hm + x*r) mod q, with a per-state watchdog.
module dsa_sign_seq #(
    parameter int W   = 512,
    parameter int TMO = 2**20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] p,
    input  logic [W-1:0] q,
    input  logic [W-1:0] g,
    input  logic [W-1:0] k,
    input  logic [W-1:0] x,
    input  logic [W-1:0] hm,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] r,
    output logic [W-1:0] s,
    output logic         exp_ds,
    output logic         exp_reset,
    output logic [W-1:0] exp_base,
    output logic [W-1:0] exp_exp,
    output logic [W-1:0] exp_mod,
    input  logic [W-1:0] exp_res,
    input  logic         exp_ready,
    output logic         mul_ds,
    output logic         mul_reset,
    output logic [W-1:0] mul_a,
    output logic [W-1:0] mul_b,
    output logic [W-1:0] mul_mod,
    input  logic [W-1:0] mul_res,
    input  logic         mul_ready,
    output logic         inv_en,
    input  logic [W-1:0] inv_res,
    input  logic         inv_rdy
);
    typedef enum logic [2:0] {IDLE, EXP, RRED, MUL1, ADD, MUL2, FIN} st_t;
    st_t st, nxt;
    logic fst, inv_held, ferr, tmo, in_mul;
    logic [W-1:0] pr, qr, gr, kr, xr, hr, red, kinv;
    logic [W:0] m;
    logic [31:0] wd;

    assign in_mul    = (st == MUL1) || (st == MUL2);
    assign tmo       = (st != IDLE) && (st != FIN) && (wd == 32'(TMO - 1));
    assign busy      = st != IDLE;
    assign done      = st == FIN;
    assign exp_ds    = (st == EXP) && fst;
    assign exp_reset = st != EXP;
    assign mul_ds    = in_mul && fst;
    assign mul_reset = !in_mul;
    assign exp_base  = gr;
    assign exp_exp   = kr;
    assign exp_mod   = pr;
    assign mul_a     = (st == MUL2) ? m[W-1:0] : red;
    assign mul_b     = (st == MUL2) ? kinv : xr;
    assign mul_mod   = qr;

    // fst marks the first cycle of a state: engine ds pulses then, and ready is ignored
    always_comb begin
        nxt  = st;
        ferr = 1'b0;
        if (tmo) begin
            nxt  = FIN;
            ferr = 1'b1;
        end else begin
            case (st)
                IDLE: if (start) begin
                    nxt  = (q == '0) ? FIN : EXP;
                    ferr = q == '0;
                end
                EXP:  nxt = (exp_ready && !fst) ? RRED : EXP;
                RRED: if (red < qr) begin
                    nxt  = (red == '0) ? FIN : MUL1;
                    ferr = red == '0;
                end
                MUL1: nxt = (mul_ready && !fst) ? ADD : MUL1;
                ADD:  nxt = (m < {1'b0, qr} && inv_held) ? MUL2 : ADD;
                MUL2: if (mul_ready && !fst) begin
                    nxt  = FIN;
                    ferr = mul_res == '0;
                end
                FIN:     nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= IDLE;
            fst      <= 1'b0;
            wd       <= '0;
            inv_en   <= 1'b0;
            inv_held <= 1'b0;
            err      <= 1'b0;
            r        <= '0;
            s        <= '0;
            pr       <= '0;
            qr       <= '0;
            gr       <= '0;
            kr       <= '0;
            xr       <= '0;
            hr       <= '0;
            red      <= '0;
            kinv     <= '0;
            m        <= '0;
        end else begin
            st  <= nxt;
            fst <= nxt != st;
            wd  <= (nxt != st) ? '0 : wd + 32'd1;
            if (st == IDLE && start) begin
                {pr, qr, gr, kr, xr, hr} <= {p, q, g, k, x, hm};
                inv_held <= 1'b0;
                inv_en   <= q != '0;
            end else if (nxt == FIN) begin
                inv_en <= 1'b0;
            end else if (inv_en && inv_rdy && !(st == EXP && fst)) begin
                kinv     <= inv_res;
                inv_held <= 1'b1;
                inv_en   <= 1'b0;
            end
            if (st == EXP && nxt == RRED)
                red <= exp_res;
            else if (st == RRED && red >= qr)
                red <= red - qr;
            if (st == MUL1 && nxt == ADD)
                m <= {1'b0, mul_res} + {1'b0, hr};
            else if (st == ADD && m >= {1'b0, qr})
                m <= m - {1'b0, qr};
            if (nxt == FIN && st != FIN) begin
                err <= ferr;
                r   <= ferr ? '0 : red;
                s   <= ferr ? '0 : mul_res;
            end
        end
    end
endmodule

// File: doc/dsa_sign_seq.md
DSA_SIGN_SEQ -- requirements
Module: dsa_sign_seq

Interface
REQ-001 Parameter W, default 512, operand and result width in bits.
REQ-002 Parameter TMO, default 2**20, maximum cycles allowed in any single busy state before abort.
REQ-003 clk  in  1  rising-edge clock; all state updates occur on this edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request one signature; p, q, g, k, x, hm are sampled in the same cycle.
REQ-006 p, q, g, k, x, hm  in  W each  DSA prime, subgroup order, generator, nonce, private key, message hash.
REQ-007 busy  out  1  high from the cycle after an accepted start until done.
REQ-008 done  out  1  single-cycle completion pulse.
REQ-009 err  out  1  status of the last run; valid from done until the next accepted start.
REQ-010 r, s  out  W each  signature; held until the next accepted start.
REQ-011 exp_ds, exp_reset  out  1 each  exponentiation engine start pulse and engine reset.
REQ-012 exp_base, exp_exp, exp_mod  out  W each  exponentiation operands (g, k, p registers).
REQ-013 exp_res  in  W  exponentiation result; exp_ready  in  1  exponentiation complete level.
REQ-014 mul_ds, mul_reset  out  1 each  shared modular multiplier start pulse and multiplier reset.
REQ-015 mul_a, mul_b, mul_mod  out  W each  multiplier operands; mul_mod is always the q register.
REQ-016 mul_res  in  W  multiplier result; mul_ready  in  1  multiplier complete level.
REQ-017 inv_en  out  1  modular inverse enable level; the inverter operands are the k and q registers.
REQ-018 inv_res  in  W  inverse result; inv_rdy  in  1  inverse complete level.

Function
REQ-019 start SHALL be accepted only in IDLE; start while busy SHALL be ignored and SHALL NOT disturb the run in progress.
REQ-020 On an accepted start, all six operand inputs SHALL be registered; exp_*, mul_* and inv operand outputs SHALL be driven from these registers only.
REQ-021 An accepted start with q==0 SHALL assert done with err=1 one cycle later, with r=s=0 and no engine started.
REQ-022 States: IDLE, EXP, RRED, MUL1, ADD, MUL2, FIN. Transitions: IDLE->EXP on start; EXP->RRED on exp_ready; RRED->MUL1 when reduction completes; MUL1->ADD on mul_ready; ADD->MUL2 when reduction completes and the inverse is held; MUL2->FIN on mul_ready; FIN->IDLE after one cycle.
REQ-023 Engine start protocol: the controller SHALL deassert the engine reset and pulse its ds for exactly one cycle on state entry; each engine's reset SHALL be high in every cycle that engine is unused.
REQ-024 The controller SHALL ignore an engine ready in the cycle its ds is high.
REQ-025 inv_en SHALL rise on entry to EXP and remain high until inv_rdy is seen; inv_res SHALL be latched then, so the inverse runs concurrently with EXP, RRED and MUL1.
REQ-026 RRED SHALL compute r = exp_res mod q by subtracting q from a W-bit register, one subtraction per cycle, while the value is >= q.
REQ-027 MUL1 SHALL compute s1 = r*x mod q (mul_a=r, mul_b=x).
REQ-028 ADD SHALL form m = s1 + hm in W+1 bits, then subtract q, one subtraction per cycle, while m >= q, giving s2.
REQ-029 ADD SHALL hold in place if the reduction is complete but the inverse is not yet latched.
REQ-030 MUL2 SHALL compute s = s2*kinv mod q (mul_a=s2, mul_b=kinv).
REQ-031 If r==0 at the end of RRED, the sequencer SHALL go straight to FIN with err=1, skipping the remaining steps.
REQ-032 If s==0 at the end of MUL2, the sequencer SHALL go to FIN with err=1.
REQ-033 Watchdog: a counter SHALL be cleared on every state change; if it reaches TMO in any busy state, the sequencer SHALL go to FIN with err=1, return all engines to reset and drop inv_en.
REQ-034 In FIN, done SHALL be asserted and busy deasserted in the following cycle.
REQ-035 r and s SHALL update only in FIN.
REQ-036 A new start SHALL be accepted no earlier than the cycle after done.

Reset
REQ-037 On reset assertion: state IDLE; busy=done=err=0; r=s=0; exp_ds=mul_ds=inv_en=0; exp_reset=mul_reset=1; watchdog and inverse-held flag cleared.
REQ-038 Reset mid-run SHALL abort immediately, with no done pulse.
REQ-039 After reset release, the first start SHALL be accepted normally.

Verification
REQ-040 Nominal run, W=16, behavioural engines: p=23, q=11, g=4, k=3, x=7, hm=5 -> exp_res=18, r=7, s1=5, s2=10, kinv=4; done pulse with r=7, s=7, err=0.
REQ-041 Same operands, inverse delayed until after MUL1 completes -> ADD holds until inv_rdy, then r=7, s=7.
REQ-042 g=1, k=3, p=23, q=11 -> exp_res=1, r=1 (a normal run); separately, a forced exp_res=11 -> r=0, done with err=1, mul_ds never pulsed.
REQ-043 exp_ready tied low with TMO=64 -> done with err=1 exactly 64 cycles after EXP entry; exp_reset high afterwards.
REQ-044 start asserted every cycle throughout a run -> exactly one done and one run; with q=0 -> done+err the next cycle.
REQ-045 reset pulsed during MUL1 -> all outputs return to their reset values, no done pulse; the next start completes with r=7, s=7.
